serial_arbiter_nm: RTL and testbench
====================================

// Module: serial_arbiter_nm
// PURPOSE
//  N-master, frame-atomic arbiter for the bit-serial bus. Supports fixed-priority
//  or round-robin selection and per-master split tracking with several splits
//  outstanding at once. Adds a resume priority for returning split owners and an
//  idle-hold timeout. Sits between the master request lines and the bus mux;
//  drives grants and the mux select.
// PARAMETERS
//  NUM_MASTERS  2  number of masters, 2..8
//  RR_MODE      0  0: fixed priority (lowest index wins); 1: round-robin
//  HOLD_MAX     16 max cycles the owner may hold the bus with no active frame; 0 disables
//  IDW          $clog2(NUM_MASTERS) master-index width (derived, not overridden)
// PORTS
//  clk_i            in  1            system clock, posedge
//  rst_ni           in  1            asynchronous reset, active low
//  req_i            in  NUM_MASTERS  per-master bus request
//  frame_active_i   in  1            frame transmission in progress
//  split_start_i    in  1            slave splits the current owner's transaction
//  split_done_i     in  1            slave completes a split
//  split_done_id_i  in  IDW          master index the split_done_i refers to
//  gnt_o            out NUM_MASTERS  one-hot grant, registered
//  msel_o           out IDW          index of the granted master; 0 when none
//  busy_o           out 1            high while in GRANT
//  split_pending_o  out NUM_MASTERS  per-master outstanding split
//  timeout_o        out 1            1-cycle pulse on a forced hold-timeout release
// BEHAVIOUR
//  Reset (async): state=IDLE, owner=0, rr_ptr=0, hold_cnt=0, split_pending=0, resume=0.
//   All outputs 0.
//  States: IDLE, GRANT. gnt_o, msel_o and busy_o decode from registered state/owner only.
//  Grant latency: req seen in IDLE at cycle t -> gnt_o high from cycle t+1.
//  eligible = req_i & ~split_pending_q. Winner selection in IDLE:
//   1. If eligible & resume_q is nonzero, the lowest index in it wins.
//   2. Else RR_MODE=0: lowest eligible index wins.
//   3. Else RR_MODE=1: first eligible index at or after rr_ptr, wrapping modulo NUM_MASTERS.
//   On a win: owner<=winner, clear resume_q[winner]. For RR, rr_ptr<=winner+1 (wraps to 0).
//  IDLE -> GRANT when eligible is nonzero; otherwise stay in IDLE.
//  GRANT exit conditions, in priority order:
//   a. split_start_i: set split_pending_q[owner]; go to IDLE. Applies even if frame_active_i is high.
//   b. !frame_active_i && !req_i[owner]: go to IDLE (normal release).
//   c. HOLD_MAX!=0 && !frame_active_i && hold_cnt==HOLD_MAX-1: go to IDLE and pulse timeout_o.
//   Otherwise stay in GRANT. No switch while frame_active_i=1, except via (a).
//  hold_cnt: cleared on GRANT entry and whenever frame_active_i=1. Increments each GRANT cycle
//   with frame_active_i=0. Saturates; never wraps.
//  Bus turnaround: every GRANT->IDLE exit spends at least one IDLE cycle with gnt_o=0 before any
//   new grant, including re-grant to the same master.
//  split_done_i: if split_pending_q[id]=1, clear it and set resume_q[id]. If not pending, ignore
//   (no state change).
//  split_done_id_i >= NUM_MASTERS: ignored.
//  Simultaneous events:
//   split_start_i and split_done_i for a different id in the same cycle: both take effect.
//   split_start_i in IDLE: ignored.
//   A pending master's req_i is masked; it is re-arbitrated after its split_done_i arrives.
//  All NUM_MASTERS masters may hold splits at once: the bus stays IDLE, gnt_o=0.
//  Reset mid-GRANT: gnt_o drops asynchronously; all split/resume state is lost.
// TESTING
//  T1 fixed prio: N=4, RR_MODE=0, req=4'b1010 at t -> gnt_o=4'b0010 at t+1, msel_o=1;
//     drop req[1] with frame low -> gnt=0 at next cycle, then gnt=4'b1000 one cycle later.
//  T2 round-robin: N=4, RR_MODE=1, req=4'b1111 held, each master drops req after 1 cycle in GRANT
//     -> grant order 0,1,2,3,0 with one idle cycle between grants.
//  T3 frame-atomic: owner M0 drops req while frame_active_i=1 for 10 cycles, req[1]=1
//     -> gnt_o stays 01 until frame low; M1 granted 2 cycles after frame falls.
//  T4 split/resume: M1 owner, split_start_i -> split_pending_o=0010, M2 and M0 served, M1 masked;
//     split_done_i id=1 with req=0111 -> M1 granted next, ahead of M0.
//  T5 timeout: HOLD_MAX=4, owner holds req with frame low -> release after 4 GRANT cycles,
//     timeout_o pulses once; frame pulse mid-hold restarts the count.
//  T6 corner: split_done_i for a non-pending id -> no change; assert rst_ni mid-GRANT
//     -> all outputs 0 immediately.

Source files
------------

// File: rtl/serial_arbiter_nm.sv
// N-master frame-atomic bus arbiter: fixed/round-robin selection,
// split tracking with resume priority and idle-hold timeout.
module serial_arbiter_nm #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter bit          RR_MODE     = 1'b0,
  parameter int unsigned HOLD_MAX    = 16,
  localparam int unsigned IDW = $clog2(NUM_MASTERS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   frame_active_i,
  input  logic                   split_start_i,
  input  logic                   split_done_i,
  input  logic [IDW-1:0]         split_done_id_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDW-1:0]         msel_o,
  output logic                   busy_o,
  output logic [NUM_MASTERS-1:0] split_pending_o,
  output logic                   timeout_o
);

  localparam int unsigned HCW =
    (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HCW-1:0] HLIM =
    HCW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [IDW-1:0] LAST =
    IDW'(NUM_MASTERS - 1);
  localparam logic [IDW:0] NM =
    (IDW+1)'(NUM_MASTERS);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e                 r_state, w_state_d;
  logic [IDW-1:0]         r_owner, w_owner_d;
  logic [IDW-1:0]         r_rr, w_rr_d;
  logic [HCW-1:0]         r_hold, w_hold_d;
  logic [NUM_MASTERS-1:0] r_split, w_split_d;
  logic [NUM_MASTERS-1:0] r_resume, w_resume_d;
  logic                   r_timeout, w_timeout_d;

  logic [NUM_MASTERS-1:0] w_elig;
  logic [NUM_MASTERS-1:0] w_hit;
  logic [IDW-1:0]         w_win;
  logic [IDW-1:0]         w_idx;
  logic                   w_win_vld;
  logic                   w_done_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr      <= '0;
      r_hold    <= '0;
      r_split   <= '0;
      r_resume  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_owner   <= w_owner_d;
      r_rr      <= w_rr_d;
      r_hold    <= w_hold_d;
      r_split   <= w_split_d;
      r_resume  <= w_resume_d;
      r_timeout <= w_timeout_d;
    end
  end

  // Downward scans leave the lowest (or first-after-pointer) hit in w_win.
  always_comb begin
    w_elig    = req_i & ~r_split;
    w_hit     = w_elig & r_resume;
    w_win_vld = |w_elig;
    w_win     = '0;
    w_idx     = '0;
    if (|w_hit) begin
      for (int i = NUM_MASTERS-1; i >= 0; i--) begin
        if (w_hit[i]) w_win = IDW'(i);
      end
    end else if (!RR_MODE) begin
      for (int i = NUM_MASTERS-1; i >= 0; i--) begin
        if (w_elig[i]) w_win = IDW'(i);
      end
    end else begin
      for (int i = NUM_MASTERS-1; i >= 0; i--) begin
        w_idx = IDW'((int'(r_rr) + i) % int'(NUM_MASTERS));
        if (w_elig[w_idx]) w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_owner_d   = r_owner;
    w_rr_d      = r_rr;
    w_hold_d    = r_hold;
    w_split_d   = r_split;
    w_resume_d  = r_resume;
    w_timeout_d = 1'b0;
    w_done_ok   = split_done_i
               && ({1'b0, split_done_id_i} < NM)
               && r_split[split_done_id_i];
    unique case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_d         = S_GRANT;
          w_owner_d         = w_win;
          w_resume_d[w_win] = 1'b0;
          w_hold_d          = '0;
          if (RR_MODE) begin
            w_rr_d = (w_win == LAST) ? '0 : w_win + 1'b1;
          end
        end
      end
      S_GRANT: begin
        if (frame_active_i) begin
          w_hold_d = '0;
        end else if (r_hold != '1) begin
          w_hold_d = r_hold + 1'b1;
        end
        if (split_start_i) begin
          w_split_d[r_owner] = 1'b1;
          w_state_d          = S_IDLE;
        end else if (!frame_active_i && !req_i[r_owner]) begin
          w_state_d = S_IDLE;
        end else if (HOLD_MAX != 0 && !frame_active_i
                     && r_hold == HLIM) begin
          w_state_d   = S_IDLE;
          w_timeout_d = 1'b1;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
    if (w_done_ok) begin
      w_split_d[split_done_id_i]  = 1'b0;
      w_resume_d[split_done_id_i] = 1'b1;
    end
  end

  always_comb begin
    busy_o          = (r_state == S_GRANT);
    gnt_o           = '0;
    msel_o          = '0;
    if (busy_o) begin
      gnt_o  = NUM_MASTERS'(1) << r_owner;
      msel_o = r_owner;
    end
    split_pending_o = r_split;
    timeout_o       = r_timeout;
  end

endmodule

// File: tb/tb_serial_arbiter_nm.sv
// Bench for serial_arbiter_nm: fixed-priority and round-robin instances
// checked every cycle against a transaction-level model plus directed pins.
module tb_serial_arbiter_nm;

  localparam int HM = 4;

  logic       clk;
  logic       rst_ni;
  logic [3:0] req  [2];
  logic       fa   [2];
  logic       ss   [2];
  logic       sd   [2];
  logic [1:0] sdid [2];
  logic [3:0] gnt  [2];
  logic [1:0] msel [2];
  logic       busy [2];
  logic [3:0] sp   [2];
  logic       to   [2];

  int n_chk  = 0;
  int n_fail = 0;

  serial_arbiter_nm #(
    .NUM_MASTERS(4), .RR_MODE(1'b0), .HOLD_MAX(HM)
  ) u_fp (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req[0]), .frame_active_i(fa[0]),
    .split_start_i(ss[0]), .split_done_i(sd[0]),
    .split_done_id_i(sdid[0]),
    .gnt_o(gnt[0]), .msel_o(msel[0]), .busy_o(busy[0]),
    .split_pending_o(sp[0]), .timeout_o(to[0])
  );

  serial_arbiter_nm #(
    .NUM_MASTERS(4), .RR_MODE(1'b1), .HOLD_MAX(HM)
  ) u_rr (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req[1]), .frame_active_i(fa[1]),
    .split_start_i(ss[1]), .split_done_i(sd[1]),
    .split_done_id_i(sdid[1]),
    .gnt_o(gnt[1]), .msel_o(msel[1]), .busy_o(busy[1]),
    .split_pending_o(sp[1]), .timeout_o(to[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d got=%0h expected=%0h t=%0t",
               nm, k, got, exp, $time);
    end
  endtask

  // Model: bus owner (-1 = bus free), pending/resume sets, pointer, idle count.
  int m_own  [2];
  int m_ptr  [2];
  int m_hold [2];
  bit m_pend [2][4];
  bit m_res  [2][4];
  bit m_to   [2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0; m_to[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_pend[k][i] = 0; m_res[k][i] = 0;
      end
    end
  endtask

  task automatic mstep(input int k);
    int w, i, o, did;
    bit dhit;
    did  = int'(sdid[k]);
    dhit = sd[k] && m_pend[k][did];
    m_to[k] = 0;
    if (m_own[k] < 0) begin
      w = -1;
      for (int n = 0; n < 4; n++)
        if (w < 0 && req[k][n] && !m_pend[k][n] && m_res[k][n]) w = n;
      for (int n = 0; n < 4; n++) begin
        i = (k == 1) ? (m_ptr[k] + n) % 4 : n;
        if (w < 0 && req[k][i] && !m_pend[k][i]) w = i;
      end
      if (w >= 0) begin
        m_own[k] = w; m_res[k][w] = 0; m_hold[k] = 0;
        if (k == 1) m_ptr[k] = (w + 1) % 4;
      end
    end else begin
      o = m_own[k];
      if (ss[k]) begin
        m_pend[k][o] = 1; m_own[k] = -1;
      end else if (!fa[k] && !req[k][o]) begin
        m_own[k] = -1;
      end else if (!fa[k] && m_hold[k] == HM - 1) begin
        m_own[k] = -1; m_to[k] = 1;
      end else begin
        m_hold[k] = fa[k] ? 0 : m_hold[k] + 1;
      end
    end
    if (dhit) begin
      m_pend[k][did] = 0; m_res[k][did] = 1;
    end
  endtask

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) mreset();
    else begin
      mstep(0);
      mstep(1);
    end
  end

  always @(negedge clk) begin
    int eg, es;
    if (rst_ni) begin
      for (int k = 0; k < 2; k++) begin
        eg = (m_own[k] >= 0) ? (1 << m_own[k]) : 0;
        es = 0;
        for (int i = 0; i < 4; i++) es |= int'(m_pend[k][i]) << i;
        chk("m_gnt", k, 32'(gnt[k]), 32'(eg));
        chk("m_msel", k, 32'(msel[k]),
            32'((m_own[k] >= 0) ? m_own[k] : 0));
        chk("m_busy", k, 32'(busy[k]), 32'(m_own[k] >= 0));
        chk("m_split", k, 32'(sp[k]), 32'(es));
        chk("m_tmo", k, 32'(to[k]), 32'(m_to[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int ord;

  initial begin
    clk = 0; rst_ni = 0;
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; fa[k] = 0; ss[k] = 0; sd[k] = 0; sdid[k] = '0;
    end
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_gnt", k, 32'(gnt[k]), 0);
      chk("rst_msel", k, 32'(msel[k]), 0);
      chk("rst_busy", k, 32'(busy[k]), 0);
      chk("rst_split", k, 32'(sp[k]), 0);
      chk("rst_tmo", k, 32'(to[k]), 0);
    end
    rst_ni = 1;

    // fixed priority
    req[0] = 4'b1010; tick();
    chk("t1_gnt", 0, 32'(gnt[0]), 32'b0010);
    chk("t1_msel", 0, 32'(msel[0]), 1);
    req[0] = 4'b1000; tick();
    chk("t1_gap", 0, 32'(gnt[0]), 0);
    tick();
    chk("t1_gnt3", 0, 32'(gnt[0]), 32'b1000);
    chk("t1_msel3", 0, 32'(msel[0]), 3);
    req[0] = '0; tick(); tick();

    // round-robin order 0,1,2,3,0 with a gap cycle between grants
    for (int n = 0; n < 5; n++) begin
      ord = n % 4;
      req[1] = 4'hF; tick();
      chk("t2_gnt", 1, 32'(gnt[1]), 32'(1 << ord));
      req[1] = 4'hF & ~(4'(1) << ord); tick();
      chk("t2_gap", 1, 32'(gnt[1]), 0);
    end
    req[1] = '0; tick();

    // frame atomicity
    req[0] = 4'b0001; tick();
    chk("t3_gnt0", 0, 32'(gnt[0]), 32'b0001);
    fa[0] = 1; req[0] = 4'b0010;
    repeat (10) begin
      tick();
      chk("t3_hold", 0, 32'(gnt[0]), 32'b0001);
    end
    fa[0] = 0; tick();
    chk("t3_gap", 0, 32'(gnt[0]), 0);
    tick();
    chk("t3_gnt1", 0, 32'(gnt[0]), 32'b0010);
    req[0] = '0; tick(); tick();

    // split and resume priority
    req[0] = 4'b0010; tick();
    chk("t4_gnt1", 0, 32'(gnt[0]), 32'b0010);
    ss[0] = 1; req[0] = 4'b0111; tick(); ss[0] = 0;
    chk("t4_pend", 0, 32'(sp[0]), 32'b0010);
    chk("t4_rel", 0, 32'(gnt[0]), 0);
    tick();
    chk("t4_m0", 0, 32'(gnt[0]), 32'b0001);
    req[0] = 4'b0110; tick();
    chk("t4_gap", 0, 32'(gnt[0]), 0);
    tick();
    chk("t4_m2", 0, 32'(gnt[0]), 32'b0100);
    req[0] = 4'b0010; tick(); tick();
    chk("t4_mask", 0, 32'(gnt[0]), 0);
    sd[0] = 1; sdid[0] = 2'd1; req[0] = '0; tick(); sd[0] = 0;
    chk("t4_done", 0, 32'(sp[0]), 0);
    req[0] = 4'b0111; tick();
    chk("t4_resume", 0, 32'(gnt[0]), 32'b0010);
    req[0] = '0; tick(); tick();

    // split_start and split_done for another id together
    req[0] = 4'b0010; tick();
    ss[0] = 1; tick(); ss[0] = 0;
    req[0] = 4'b0001; tick();
    chk("t4b_m0", 0, 32'(gnt[0]), 32'b0001);
    ss[0] = 1; sd[0] = 1; sdid[0] = 2'd1; tick();
    ss[0] = 0; sd[0] = 0;
    chk("t4b_pend", 0, 32'(sp[0]), 32'b0001);
    chk("t4b_rel", 0, 32'(gnt[0]), 0);
    req[0] = '0; sd[0] = 1; sdid[0] = 2'd0; tick(); sd[0] = 0;
    chk("t4b_clr", 0, 32'(sp[0]), 0);

    // hold timeout, then restart of the count by a frame pulse
    req[0] = 4'b0001; tick();
    chk("t5_gnt", 0, 32'(gnt[0]), 32'b0001);
    repeat (3) begin
      tick();
      chk("t5_hold", 0, 32'(gnt[0]), 32'b0001);
    end
    tick();
    chk("t5_rel", 0, 32'(gnt[0]), 0);
    chk("t5_tmo", 0, 32'(to[0]), 1);
    tick();
    chk("t5_tmo_end", 0, 32'(to[0]), 0);
    chk("t5_regnt", 0, 32'(gnt[0]), 32'b0001);
    tick(); tick();
    fa[0] = 1; tick();
    chk("t5_fpulse", 0, 32'(gnt[0]), 32'b0001);
    fa[0] = 0;
    repeat (3) begin
      tick();
      chk("t5_hold2", 0, 32'(gnt[0]), 32'b0001);
    end
    tick();
    chk("t5_rel2", 0, 32'(gnt[0]), 0);
    chk("t5_tmo2", 0, 32'(to[0]), 1);
    req[0] = '0; tick(); tick();

    // split_done for a non-pending id, then reset mid-grant
    sd[0] = 1; sdid[0] = 2'd2; tick(); sd[0] = 0;
    chk("t6_nopend", 0, 32'(sp[0]), 0);
    req[0] = 4'b0101; tick();
    chk("t6_noresume", 0, 32'(gnt[0]), 32'b0001);
    #2 rst_ni = 0;
    #1;
    chk("t6_rst_gnt", 0, 32'(gnt[0]), 0);
    chk("t6_rst_busy", 0, 32'(busy[0]), 0);
    chk("t6_rst_msel", 0, 32'(msel[0]), 0);
    tick();
    req[0] = '0; rst_ni = 1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
